// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with per-frame input snapshot.
// Ports: clk, reset_p (async, active-high); value/dp_en/blank_lz/blink_mask
// in; com (active-low digit enables), seg_7 (active-low dp,g..a), frame_tick out.
module fnd_scan_driver #(
    parameter int SCAN_DIV     = 125000,
    parameter int BLANK_CYC    = 64,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  com,
    output logic [7:0]  seg_7,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          started;

    logic [15:0]   value_sh;
    logic [3:0]    dp_sh;
    logic          lz_sh;
    logic [3:0]    blink_sh;

    logic          snap;
    logic          scan_last;
    logic          frame_wrap;

    // View of the frame state as it will be after this edge, so the
    // first digit of a frame already uses the fresh snapshot and phase.
    logic [15:0]   value_e;
    logic [3:0]    dp_e;
    logic          lz_e;
    logic [3:0]    blink_e;
    logic          phase_e;

    logic [3:0]    nib;
    logic [3:0]    lz_vec;
    logic [3:0]    com_n;
    logic [7:0]    seg_n;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign snap      = (idx == 2'd0) && (scan_cnt == '0);
    assign scan_last = (scan_cnt == CW'(SCAN_DIV - 1));

    // The very first snapshot after reset opens frame 0; every later
    // snapshot closes one frame, which is what the blink counter counts.
    assign frame_wrap = snap && started &&
                        (frame_cnt == FW'(BLINK_FRAMES - 1));

    assign value_e = snap ? value      : value_sh;
    assign dp_e    = snap ? dp_en      : dp_sh;
    assign lz_e    = snap ? blank_lz   : lz_sh;
    assign blink_e = snap ? blink_mask : blink_sh;
    assign phase_e = frame_wrap ? ~blink_phase : blink_phase;

    assign nib = value_e[{idx, 2'b00} +: 4];

    // Leading-zero chain runs from the most significant digit downward;
    // a lit decimal point stops the chain.
    always_comb begin
        lz_vec    = 4'b0000;
        lz_vec[3] = lz_e && (value_e[15:12] == 4'h0) && !dp_e[3];
        lz_vec[2] = lz_vec[3] && (value_e[11:8] == 4'h0) && !dp_e[2];
        lz_vec[1] = lz_vec[2] && (value_e[7:4] == 4'h0) && !dp_e[1];
        lz_vec[0] = 1'b0;
    end

    always_comb begin
        com_n = 4'hF;
        seg_n = 8'hFF;
        if (scan_cnt >= CW'(BLANK_CYC)) begin
            com_n = ~(4'b0001 << idx);
            if (phase_e && blink_e[idx]) begin
                seg_n = 8'hFF;
            end else if (lz_vec[idx]) begin
                seg_n = 8'hFF;
            end else begin
                seg_n = ~{dp_e[idx], glyph(nib)};
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_last) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            value_sh <= 16'h0000;
            dp_sh    <= 4'h0;
            lz_sh    <= 1'b0;
            blink_sh <= 4'h0;
        end else if (snap) begin
            value_sh <= value;
            dp_sh    <= dp_en;
            lz_sh    <= blank_lz;
            blink_sh <= blink_mask;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            started     <= 1'b0;
        end else if (snap) begin
            started <= 1'b1;
            if (frame_wrap) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else if (started) begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            com        <= 4'hF;
            seg_7      <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            com        <= com_n;
            seg_7      <= seg_n;
            frame_tick <= snap;
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Scoreboard bench for fnd_scan_driver: per-frame expected digits are
// queued at each snapshot and a negedge monitor pops them as digits light.
module tb_fnd_scan_driver;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset_p = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_en = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  com;
    logic [7:0]  seg_7;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    bit mon_en = 1'b0;

    logic [6:0] glyph_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    fnd_scan_driver #(
        .SCAN_DIV(SD),
        .BLANK_CYC(BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .value(value),
        .dp_en(dp_en),
        .blank_lz(blank_lz),
        .blink_mask(blink_mask),
        .com(com),
        .seg_7(seg_7),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, want, $time);
        end
    endtask

    // Reference: the expected {com, seg_7} of digit k for one frame.
    function automatic logic [11:0] expect_digit(input int k,
            input logic [15:0] v, input logic [3:0] dp, input logic lz,
            input logic [3:0] bm, input bit phase);
        bit blanked [4];
        bit run;
        logic [7:0] s;
        logic [3:0] n;
        run = lz;
        for (int d = 3; d >= 1; d--) begin
            run = run && (v[d*4 +: 4] == 4'h0) && !dp[d];
            blanked[d] = run;
        end
        blanked[0] = 1'b0;
        n = v[k*4 +: 4];
        if (phase && bm[k])
            s = 8'hFF;
        else if (blanked[k])
            s = 8'hFF;
        else
            s = ~{dp[k], glyph_tbl[n]};
        return {~(4'b0001 << k), s};
    endfunction

    // Random value with plenty of zero nibbles to exercise blanking.
    function automatic logic [15:0] rnd_value();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        return v;
    endfunction

    // Entered at the negedge before a snapshot edge; leaves ncyc
    // negedges later. Inputs are scrambled once mid-frame.
    task automatic do_frame(input int f, input logic [15:0] v,
            input logic [3:0] dp, input logic lz, input logic [3:0] bm,
            input int ncyc);
        bit phase;
        int k;
        phase = ((f / BF) % 2) == 1;
        value = v;
        dp_en = dp;
        blank_lz = lz;
        blink_mask = bm;
        for (int d = 0; d < 4; d++)
            exp_q.push_back(expect_digit(d, v, dp, lz, bm, phase));
        k = $urandom_range(1, ncyc - 1);
        repeat (k) @(negedge clk);
        value = rnd_value();
        dp_en = 4'($urandom);
        blank_lz = 1'($urandom);
        blink_mask = 4'($urandom);
        repeat (ncyc - k) @(negedge clk);
    endtask

    task automatic startup_checks();
        @(negedge clk);
        check("first_tick", frame_tick, 1);
        check("first_com_blank", com, 4'hF);
        @(negedge clk);
        check("tick_one_cycle", frame_tick, 0);
        check("second_com_blank", com, 4'hF);
        @(negedge clk);
        check("first_lit_digit0", com, 4'hE);
    endtask

    task automatic random_frames(input int first, input int last);
        for (int f = first; f <= last; f++)
            do_frame(f, rnd_value(), 4'($urandom), 1'($urandom),
                     4'($urandom), FRAME);
    endtask

    logic [3:0]  prev_com;
    logic [11:0] cur;
    int lit_run, blank_run, cyc, last_tick;
    bit seen_tick;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_com = 4'hF;
            cur = 12'h000;
            lit_run = 0;
            blank_run = 0;
            cyc = 0;
            last_tick = 0;
            seen_tick = 1'b0;
        end else begin
            cyc++;
            if (frame_tick === 1'b1) begin
                if (seen_tick)
                    check("tick_period", cyc - last_tick, FRAME);
                seen_tick = 1'b1;
                last_tick = cyc;
            end
            if (com === 4'hF) begin
                check("blank_seg", seg_7, 8'hFF);
                if (prev_com !== 4'hF)
                    check("lit_len", lit_run, SD - BC);
                blank_run = (prev_com === 4'hF) ? blank_run + 1 : 1;
                lit_run = 0;
            end else begin
                if (prev_com === 4'hF) begin
                    check("blank_len", blank_run, BC);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_underflow: digit %b lit with nothing expected",
                                 com);
                        cur = 12'h000;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                lit_run++;
                check("digit", {com, seg_7}, cur);
            end
            prev_com = com;
        end
    end

    initial begin
        #1 reset_p = 1'b1;
        #1;
        check("reset_com", com, 4'hF);
        check("reset_seg", seg_7, 8'hFF);
        check("reset_tick", frame_tick, 0);
        repeat (3) @(negedge clk);

        reset_p = 1'b0;
        #1 mon_en = 1'b1;
        fork
            do_frame(0, 16'h1234, 4'h0, 1'b0, 4'b0001, FRAME);
            startup_checks();
        join
        do_frame(1, 16'h0005, 4'h0, 1'b1, 4'b0001, FRAME);
        do_frame(2, 16'h0005, 4'b0100, 1'b1, 4'h0, FRAME);
        do_frame(3, 16'h1234, 4'h0, 1'b0, 4'b0001, FRAME);
        do_frame(4, 16'h5678, 4'h0, 1'b0, 4'h0, FRAME);
        do_frame(5, 16'h1234, 4'h0, 1'b0, 4'b0001, FRAME);
        random_frames(6, 13);

        // Stop with digit 2 lit and three cycles of its period left.
        do_frame(14, rnd_value(), 4'($urandom), 1'($urandom),
                 4'($urandom), 21);
        mon_en = 1'b0;
        check("pre_reset_com", com, 4'b1011);
        #1 reset_p = 1'b1;
        #1;
        check("async_reset_com", com, 4'hF);
        check("async_reset_seg", seg_7, 8'hFF);
        check("async_reset_tick", frame_tick, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);

        reset_p = 1'b0;
        #1 mon_en = 1'b1;
        fork
            do_frame(0, rnd_value(), 4'($urandom), 1'($urandom),
                     4'($urandom), FRAME);
            startup_checks();
        join
        random_frames(1, 5);

        mon_en = 1'b0;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
